// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider seq_div_8by4.
// Optional feature macro used by the top: DIV_ZERO_FAST_EN.
package div_pkg;

    // Default operand widths: 8-bit dividend/quotient, 4-bit divisor/remainder.
    localparam int DIVIDEND_W_DEF = 8;
    localparam int DIVISOR_W_DEF  = 4;

    // Width of the RUN-cycle counter for the default dividend width.
    localparam int CNT_W = $clog2(DIVIDEND_W_DEF + 1);

    // Cycles from an accepted start to the done pulse for a normal operation.
    localparam int DIV_LATENCY = DIVIDEND_W_DEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage : div_pkg

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor when it fits, report the quotient bit.
// Purely combinational so an unrolled divider can chain several copies.
module div_step #(
    parameter int DIVISOR_W = 4
) (
    input  logic [DIVISOR_W:0]   r_in,
    input  logic                 next_bit,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W:0]   r_out,
    output logic                 q_bit
);

    logic [DIVISOR_W:0] r_shift;
    logic [DIVISOR_W:0] divisor_ext;

    // Trial subtraction; keep the shifted value when the divisor does not fit.
    always_comb begin
        r_shift     = {r_in[DIVISOR_W-1:0], next_bit};
        divisor_ext = {1'b0, divisor};
        q_bit       = (r_shift >= divisor_ext);
        r_out       = q_bit ? (r_shift - divisor_ext) : r_shift;
    end

endmodule : div_step

// File: rtl/seq_div_8by4.sv
// Sequential restoring divider, one quotient bit per clock, MSB first.
// Start/ready/done handshake; results held in output registers until the
// next done pulse.
// Optional feature macro: DIV_ZERO_FAST_EN -- a zero divisor finishes one
// cycle after accept instead of running the full DIVIDEND_W steps.
module seq_div_8by4
    import div_pkg::*;
#(
    parameter int DIVIDEND_W = DIVIDEND_W_DEF,
    parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  ready,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int CNT_BITS = $clog2(DIVIDEND_W + 1);
    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DIVIDEND_W - 1);

    div_state_t            state_q, state_d;
    logic [CNT_BITS-1:0]   cnt_q, cnt_d;
    logic [DIVISOR_W:0]    r_q, r_d;      // partial remainder, one guard bit
    logic [DIVIDEND_W-1:0] dvd_q, dvd_d;  // dividend shifts out, quotient shifts in
    logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
    logic [DIVIDEND_W-1:0] quo_q, quo_d;
    logic [DIVISOR_W-1:0]  rem_q, rem_d;
    logic                  dbz_q, dbz_d;

    logic [DIVISOR_W:0]    step_r;
    logic                  step_q_bit;
    logic                  zero_div_at_accept;

    div_step #(
        .DIVISOR_W (DIVISOR_W)
    ) u_step (
        .r_in     (r_q),
        .next_bit (dvd_q[DIVIDEND_W-1]),
        .divisor  (dvs_q),
        .r_out    (step_r),
        .q_bit    (step_q_bit)
    );

    // Detect a zero divisor at accept; only the fast variant acts on it.
`ifdef DIV_ZERO_FAST_EN
    assign zero_div_at_accept = (divisor == '0);
`else
    assign zero_div_at_accept = 1'b0;
`endif

    // Next-state and datapath update for the IDLE/RUN/DONE controller.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    dvd_d   = dividend;
                    dvs_d   = divisor;
                    r_d     = '0;
                    // A fast zero-divide jumps straight to the last RUN edge,
                    // so done follows one cycle after accept.
                    cnt_d   = zero_div_at_accept ? CNT_LAST : '0;
                    state_d = RUN;
                end
            end

            RUN: begin
                dvd_d = {dvd_q[DIVIDEND_W-2:0], step_q_bit};
                r_d   = step_r;
                cnt_d = cnt_q + CNT_BITS'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    if (dvs_q == '0) begin
                        // Datapath result is meaningless for a zero divisor.
                        quo_d = '1;
                        rem_d = '0;
                        dbz_d = 1'b1;
                    end else begin
                        quo_d = {dvd_q[DIVIDEND_W-2:0], step_q_bit};
                        rem_d = step_r[DIVISOR_W-1:0];
                        dbz_d = 1'b0;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values; all registers are small flops, so all are reset.
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign ready       = (state_q == IDLE);
    assign done        = (state_q == DONE);
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule : seq_div_8by4

// File: tb/tb_seq_div_8by4.sv
// Self-checking bench for seq_div_8by4: directed operand pairs, zero divisor,
// held start with changing operands, mid-operation reset and a sweep over all
// 4096 operand pairs in a random order, against arithmetic / and %.
module tb_seq_div_8by4;
    import div_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] dividend = '0;
    logic [3:0] divisor = '0;
    logic       ready, done, div_by_zero;
    logic [7:0] quotient;
    logic [3:0] remainder;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int a;
        int d;
        int acc;
    } op_t;

    op_t pend[$];

    seq_div_8by4 dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .ready       (ready),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_q(input int a, input int d);
        return (d == 0) ? 255 : a / d;
    endfunction

    function automatic int ref_r(input int a, input int d);
        return (d == 0) ? 0 : a % d;
    endfunction

    function automatic int ref_lat(input int d);
`ifdef DIV_ZERO_FAST_EN
        return (d == 0) ? 1 : DIV_LATENCY;
`else
        return DIV_LATENCY + 0 * d;
`endif
    endfunction

    // One full operation: wait for ready, accept, scramble operands, await done.
    task automatic run_op(input int a, input int d, input string tag, input bit full);
        int         acc;
        int         lat;
        bit         got_ready;
        bit         got_done;
        bit         stable;
        logic [7:0] hq;
        logic [3:0] hr;
        logic       hz;
        got_ready = 0;
        for (int i = 0; i < 30 && !got_ready; i++) begin
            @(negedge clk);
            got_ready = ready;
        end
        if (!got_ready) begin
            check({tag, "_ready_timeout"}, 0, 1);
            return;
        end
        hq = quotient; hr = remainder; hz = div_by_zero;
        dividend = a[7:0];
        divisor  = d[3:0];
        start    = 1'b1;
        acc      = cyc + 1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 8'($urandom);
        divisor  = 4'($urandom);
        stable   = 1;
        got_done = 0;
        for (int i = 0; i < 30 && !got_done; i++) begin
            @(negedge clk);
            if (done) got_done = 1;
            else if (quotient !== hq || remainder !== hr || div_by_zero !== hz) stable = 0;
        end
        if (!got_done) begin
            check({tag, "_done_timeout"}, 0, 1);
            return;
        end
        lat = cyc - acc;
        check({tag, "_q"}, quotient, ref_q(a, d));
        check({tag, "_r"}, remainder, ref_r(a, d));
        check({tag, "_dbz"}, div_by_zero, (d == 0));
        check({tag, "_lat"}, lat, ref_lat(d));
        if (full) begin
            check({tag, "_stable"}, stable, 1);
            check({tag, "_ready_in_done"}, ready, 0);
            if (d != 0)
                check({tag, "_identity"},
                      (int'(quotient) * d + int'(remainder) == a) && (int'(remainder) < d), 1);
            @(negedge clk);
            check({tag, "_done_one_cycle"}, done, 0);
        end
    endtask

    initial begin
        int mul;
        int off;
        int results;
        op_t o;

        // Reset values.
        repeat (2) @(negedge clk);
        check("rst_done", done, 0);
        check("rst_q", quotient, 0);
        check("rst_r", remainder, 0);
        check("rst_dbz", div_by_zero, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", ready, 1);

        // Products of the 4x4 multiplier recover the other factor exactly.
        run_op(144, 12, "p144_12", 1);
        run_op(169, 13, "p169_13", 1);
        run_op(110, 11, "p110_11", 1);
        run_op(165, 11, "p165_11", 1);
        run_op(200, 7, "d200_7", 1);
        run_op(255, 1, "d255_1", 1);
        run_op(0, 9, "d0_9", 1);
        run_op(255, 15, "d255_15", 1);

        // Zero divisor, then a normal op clears the flag.
        run_op(5, 0, "z5_0", 1);
        run_op(6, 3, "d6_3", 1);

        // start held high while operands change every cycle.
        results = 0;
        pend.delete();
        @(negedge clk);
        for (int i = 0; i < 75; i++) begin
            if (pend.size() > 0) check("held_ready_busy", ready, 0);
            if (done) begin
                if (pend.size() == 0) check("held_unexpected_done", 0, 1);
                else begin
                    o = pend.pop_front();
                    results++;
                    check("held_q", quotient, ref_q(o.a, o.d));
                    check("held_r", remainder, ref_r(o.a, o.d));
                    check("held_lat", cyc - o.acc, ref_lat(o.d));
                end
            end
            start    = (i < 45);
            dividend = 8'($urandom);
            divisor  = 4'($urandom_range(15, 1));
            if (ready && start) begin
                o.a = int'(dividend); o.d = int'(divisor); o.acc = cyc + 1;
                pend.push_back(o);
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("held_results", results >= 4, 1);
        check("held_drained", pend.size(), 0);

        // Reset pulsed during the 4th RUN cycle of 144/12.
        @(negedge clk);
        dividend = 8'd144; divisor = 4'd12; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #2;
        check("mid_rst_done", done, 0);
        check("mid_rst_q", quotient, 0);
        check("mid_rst_r", remainder, 0);
        check("mid_rst_dbz", div_by_zero, 0);
        #1 rst = 1'b0;
        #1;
        check("mid_rst_ready", ready, 1);
        run_op(110, 11, "after_rst", 1);

        // All operand pairs, visited in a random permutation order.
        mul = int'($urandom_range(2047, 0)) * 2 + 1;
        off = int'($urandom_range(4095, 0));
        for (int i = 0; i < 4096; i++) begin
            int p;
            p = (i * mul + off) % 4096;
            run_op(p >> 4, p & 15, "sweep", (i % 64) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_seq_div_8by4
